// File: rtl/iq_demod_acc_if.sv
// Result handshake bus of iq_demod_acc: one complex correlation per lane per frame,
// plus the optional raw sample sum.
interface iq_demod_acc_if #(
  parameter int unsigned FREQ_NUM = 5,
  parameter int unsigned ACCW     = 48
);
  logic                     res_valid;
  logic                     res_ready;
  logic [ACCW*FREQ_NUM-1:0] res_idata;
  logic [ACCW*FREQ_NUM-1:0] res_qdata;
  logic [ACCW-1:0]          res_dcdata;

  modport master (
    output res_valid,
    output res_idata,
    output res_qdata,
    output res_dcdata,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_idata,
    input  res_qdata,
    input  res_dcdata,
    output res_ready
  );
endinterface

// File: rtl/iq_demod_acc.sv
// I/Q correlation accumulator: AD sample x per-lane reference PCM, summed per frame.
// Optional raw-sample sum on res_dcdata is built when IQ_DEMOD_DC_SUM_EN is defined.
module iq_demod_acc #(
  parameter int unsigned FREQ_NUM = 5,
  parameter int unsigned ADW      = 14,
  parameter int unsigned LENW     = 16,
  parameter int unsigned ACCW     = 48
) (
  input  logic                   ad_clk,
  input  logic                   rst_n,
  input  logic [ADW-1:0]         ad_data,
  input  logic                   sc_ad_valid,
  input  logic                   sc_iqpcm_valid,
  input  logic [16*FREQ_NUM-1:0] sc_ipcm_out,
  input  logic [16*FREQ_NUM-1:0] sc_qpcm_out,
  input  logic                   run,
  input  logic [LENW-1:0]        acc_length,
  output logic                   busy,
  output logic                   overrun,
  output logic                   sync_err,
  iq_demod_acc_if.master         res
);

  localparam int unsigned PW = ADW + 16;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SYNC = 2'd1;
  localparam logic [1:0] ACC       = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW:0]   cnt_inc;
  logic            run_q, run_rise;
  logic            overrun_q, sync_err_q;
  logic            sync_set;
  logic            accept, first, last;

  logic                          s1_vld_q, s1_first_q, s1_last_q;
  logic [ADW-1:0]                s1_ad_q;
  logic [FREQ_NUM-1:0][15:0]     s1_ipcm_q, s1_qpcm_q;
  logic [PW-1:0]                 s1_ad_ext;
  logic [FREQ_NUM-1:0][PW-1:0]   iprod, qprod;

  logic                          s2_vld_q, s2_first_q, s2_last_q;
  logic [FREQ_NUM-1:0][PW-1:0]   s2_iprod_q, s2_qprod_q;

  logic [FREQ_NUM-1:0][ACCW-1:0] acc_i_q, acc_q_q;
  logic [FREQ_NUM-1:0][ACCW-1:0] acc_i_nx, acc_q_nx;

  logic                          res_valid_q;
  logic [FREQ_NUM-1:0][ACCW-1:0] res_i_q, res_q_q;
  logic                          res_load, res_drop;

  assign run_rise = run & ~run_q;
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign accept   = (state_q == ACC) & run & sc_iqpcm_valid & sc_ad_valid;
  assign first    = accept & (cnt_q == '0);
  assign last     = accept & (cnt_inc == {1'b0, len_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sync_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run && acc_length != '0) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!run) begin
          state_d = IDLE;
        end else if (sc_iqpcm_valid) begin
          len_d   = acc_length;
          cnt_d   = '0;
          state_d = (acc_length == '0) ? IDLE : ACC;
        end
      end
      ACC: begin
        if (!run) begin
          state_d = IDLE;
        end else if (!sc_iqpcm_valid) begin
          // Partial sums die in the accumulator; the next first-of-frame reloads it.
          state_d  = WAIT_SYNC;
          sync_set = 1'b1;
        end else if (sc_ad_valid) begin
          if (last) begin
            cnt_d = '0;
            len_d = acc_length;
            if (acc_length == '0) state_d = IDLE;
          end else begin
            cnt_d = cnt_inc[LENW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      run_q      <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      run_q   <= run;
      if (run_rise) begin
        overrun_q  <= 1'b0;
        sync_err_q <= 1'b0;
      end
      if (sync_set) sync_err_q <= 1'b1;
      if (res_drop) overrun_q  <= 1'b1;
    end
  end

  // Stage 2 products: operands pre-extended so the low PW bits are the signed product.
  always_comb begin
    s1_ad_ext = {{16{s1_ad_q[ADW-1]}}, s1_ad_q};
    for (int unsigned i = 0; i < FREQ_NUM; i++) begin
      iprod[i] = s1_ad_ext * {{ADW{s1_ipcm_q[i][15]}}, s1_ipcm_q[i]};
      qprod[i] = s1_ad_ext * {{ADW{s1_qpcm_q[i][15]}}, s1_qpcm_q[i]};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < FREQ_NUM; i++) begin
      acc_i_nx[i] = {{(ACCW-PW){s2_iprod_q[i][PW-1]}}, s2_iprod_q[i]};
      acc_q_nx[i] = {{(ACCW-PW){s2_qprod_q[i][PW-1]}}, s2_qprod_q[i]};
      if (!s2_first_q) begin
        acc_i_nx[i] = acc_i_q[i] + acc_i_nx[i];
        acc_q_nx[i] = acc_q_q[i] + acc_q_nx[i];
      end
    end
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ad_q    <= '0;
      s1_ipcm_q  <= '0;
      s1_qpcm_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_iprod_q <= '0;
      s2_qprod_q <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
    end else begin
      s1_vld_q   <= accept;
      s1_first_q <= first;
      s1_last_q  <= last;
      s1_ad_q    <= ad_data;
      s1_ipcm_q  <= sc_ipcm_out;
      s1_qpcm_q  <= sc_qpcm_out;
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_iprod_q <= iprod;
      s2_qprod_q <= qprod;
      if (s2_vld_q) begin
        acc_i_q <= acc_i_nx;
        acc_q_q <= acc_q_nx;
      end
    end
  end

  // A completing handshake frees the slot in the same cycle a new result arrives.
  assign res_load = s2_vld_q & s2_last_q & (~res_valid_q | res.res_ready);
  assign res_drop = s2_vld_q & s2_last_q & res_valid_q & ~res.res_ready;

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_i_q     <= '0;
      res_q_q     <= '0;
    end else if (res_load) begin
      res_valid_q <= 1'b1;
      res_i_q     <= acc_i_nx;
      res_q_q     <= acc_q_nx;
    end else if (res_valid_q && res.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef IQ_DEMOD_DC_SUM_EN
  logic [ADW-1:0]  s2_ad_q;
  logic [ACCW-1:0] acc_dc_q, acc_dc_nx, res_dc_q;

  always_comb begin
    acc_dc_nx = {{(ACCW-ADW){s2_ad_q[ADW-1]}}, s2_ad_q};
    if (!s2_first_q) acc_dc_nx = acc_dc_q + acc_dc_nx;
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ad_q  <= '0;
      acc_dc_q <= '0;
      res_dc_q <= '0;
    end else begin
      s2_ad_q <= s1_ad_q;
      if (s2_vld_q) acc_dc_q <= acc_dc_nx;
      if (res_load) res_dc_q <= acc_dc_nx;
    end
  end

  assign res.res_dcdata = res_dc_q;
`else
  assign res.res_dcdata = '0;
`endif

  assign res.res_valid = res_valid_q;
  assign res.res_idata = res_i_q;
  assign res.res_qdata = res_q_q;
  assign busy          = (state_q == WAIT_SYNC) | (state_q == ACC);
  assign overrun       = overrun_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_iq_demod_acc.sv
// Self-checking bench for iq_demod_acc: randomized frames against a sum-of-products model.
// Honours IQ_DEMOD_DC_SUM_EN when checking res_dcdata.
module tb_iq_demod_acc;
  localparam int unsigned FREQ_NUM = 5;
  localparam int unsigned ADW      = 14;
  localparam int unsigned LENW     = 16;
  localparam int unsigned ACCW     = 48;
  localparam int          NB2B     = 6;

  logic                   ad_clk = 1'b0;
  logic                   rst_n  = 1'b0;
  logic [ADW-1:0]         ad_data = '0;
  logic                   sc_ad_valid = 1'b0;
  logic                   sc_iqpcm_valid = 1'b0;
  logic [16*FREQ_NUM-1:0] sc_ipcm_out = '0;
  logic [16*FREQ_NUM-1:0] sc_qpcm_out = '0;
  logic                   run = 1'b0;
  logic [LENW-1:0]        acc_length = '0;
  logic                   busy, overrun, sync_err;

  iq_demod_acc_if #(.FREQ_NUM(FREQ_NUM), .ACCW(ACCW)) res_if ();

  iq_demod_acc #(.FREQ_NUM(FREQ_NUM), .ADW(ADW), .LENW(LENW), .ACCW(ACCW)) dut (
    .ad_clk         (ad_clk),
    .rst_n          (rst_n),
    .ad_data        (ad_data),
    .sc_ad_valid    (sc_ad_valid),
    .sc_iqpcm_valid (sc_iqpcm_valid),
    .sc_ipcm_out    (sc_ipcm_out),
    .sc_qpcm_out    (sc_qpcm_out),
    .run            (run),
    .acc_length     (acc_length),
    .busy           (busy),
    .overrun        (overrun),
    .sync_err       (sync_err),
    .res            (res_if)
  );

  always #5 ad_clk = ~ad_clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_i[FREQ_NUM];
  longint exp_q[FREQ_NUM];
  longint exp_dc;

  task automatic step();
    @(posedge ad_clk);
    #1;
  endtask

  // Drives samples until len are accepted; acceptance is possible from driven cycle `lead`.
  // mode: 0 random dense, 1 random every other cycle, 2 full-scale, 3 fixed small values.
  task automatic feed_frame(input int len, input int lead, input int mode);
    int                cnt = 0;
    int                i = 0;
    logic [31:0]       r;
    logic signed [ADW-1:0] a;
    logic signed [15:0]    ip, qp;
    logic              v;
    for (int l = 0; l < FREQ_NUM; l++) begin
      exp_i[l] = 0;
      exp_q[l] = 0;
    end
    exp_dc = 0;
    while (cnt < len) begin
      v = (mode == 1) ? ((i % 2) == 1) : 1'b1;
      r = $urandom;
      a = (mode == 2) ? -14'sd8192 : (mode == 3) ? 14'sd100 : r[ADW-1:0];
      ad_data     = a;
      sc_ad_valid = v;
      for (int l = 0; l < FREQ_NUM; l++) begin
        r  = $urandom;
        ip = (mode == 2) ? -16'sd32768 : (mode == 3) ? 16'sd1000 : r[15:0];
        qp = (mode == 2) ? 16'sd32767 : (mode == 3) ? -16'sd1000 : r[31:16];
        sc_ipcm_out[16*l +: 16] = ip;
        sc_qpcm_out[16*l +: 16] = qp;
        if (i >= lead && v) begin
          exp_i[l] += longint'(a) * longint'(ip);
          exp_q[l] += longint'(a) * longint'(qp);
        end
      end
      if (i >= lead && v) begin
        exp_dc += longint'(a);
        cnt++;
      end
      step();
      i++;
    end
  endtask

  task automatic test_reset();
    logic [ACCW-1:0] zero = '0;
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b busy=%b ovr=%b serr=%b, required all 0",
               res_if.res_valid, busy, overrun, sync_err);
    end
    n_checks++;
    if (res_if.res_idata !== '0 || res_if.res_qdata !== '0 || res_if.res_dcdata !== zero) begin
      n_fail++;
      $display("FAIL reset_data: result buses not zero");
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    res_if.res_ready = 1'b0;
    sc_iqpcm_valid   = 1'b1;
    acc_length       = 16'd4;
    run              = 1'b1;
    feed_frame(4, 2, 3);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %b required 0 two cycles after last sample",
               res_if.res_valid);
    end
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid_latency: got %b required 1 three cycles after last sample",
               res_if.res_valid);
    end
    for (int l = 0; l < FREQ_NUM; l++) begin
      n_checks++;
      if ($signed(res_if.res_idata[ACCW*l +: ACCW]) !== 48'sd400000 ||
          $signed(res_if.res_qdata[ACCW*l +: ACCW]) !== -48'sd400000) begin
        n_fail++;
        $display("FAIL basic_sum lane %0d: got I=%0d Q=%0d required I=400000 Q=-400000", l,
                 $signed(res_if.res_idata[ACCW*l +: ACCW]),
                 $signed(res_if.res_qdata[ACCW*l +: ACCW]));
      end
    end
    n_checks++;
`ifdef IQ_DEMOD_DC_SUM_EN
    if ($signed(res_if.res_dcdata) !== 48'sd400) begin
`else
    if (res_if.res_dcdata !== '0) begin
`endif
      n_fail++;
      $display("FAIL basic_dc: got %0d", $signed(res_if.res_dcdata));
    end
    res_if.res_ready = 1'b1;
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: got valid=%b required 0", res_if.res_valid);
    end
    res_if.res_ready = 1'b0;
  endtask

  task automatic test_overrun();
    longint sav_i[FREQ_NUM];
    longint sav_q[FREQ_NUM];
    logic [ACCW-1:0] ei, eq;
    acc_length = 16'd2;
    run        = 1'b1;
    feed_frame(2, 2, 0);
    for (int l = 0; l < FREQ_NUM; l++) begin
      sav_i[l] = exp_i[l];
      sav_q[l] = exp_q[l];
    end
    feed_frame(2, 0, 0);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (overrun !== 1'b1 || res_if.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got ovr=%b valid=%b required 1/1", overrun, res_if.res_valid);
    end
    for (int l = 0; l < FREQ_NUM; l++) begin
      ei = ACCW'(sav_i[l]);
      eq = ACCW'(sav_q[l]);
      n_checks++;
      if (res_if.res_idata[ACCW*l +: ACCW] !== ei || res_if.res_qdata[ACCW*l +: ACCW] !== eq) begin
        n_fail++;
        $display("FAIL overrun_keep lane %0d: got I=%0d required I=%0d", l,
                 $signed(res_if.res_idata[ACCW*l +: ACCW]), $signed(ei));
      end
    end
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
    n_checks++;
    if (res_if.res_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_release: got valid=%b ovr=%b required 0/1",
               res_if.res_valid, overrun);
    end
  endtask

  task automatic test_sync_loss();
    logic            seen = 1'b0;
    logic [ACCW-1:0] ei, eq;
    acc_length = 16'd8;
    run        = 1'b1;
    feed_frame(3, 2, 0);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL run_edge_clears_overrun: got %b required 0", overrun);
    end
    sc_iqpcm_valid = 1'b0;
    sc_ad_valid    = 1'b1;
    step();
    n_checks++;
    if (sync_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_err_set: got serr=%b busy=%b required 1/1", sync_err, busy);
    end
    repeat (5) begin
      step();
      if (res_if.res_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_no_result: got a result from a broken frame, required none");
    end
    sc_iqpcm_valid = 1'b1;
    feed_frame(8, 1, 0);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b1 || sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_recover: got valid=%b serr=%b required 1/1", res_if.res_valid, sync_err);
    end
    for (int l = 0; l < FREQ_NUM; l++) begin
      ei = ACCW'(exp_i[l]);
      eq = ACCW'(exp_q[l]);
      n_checks++;
      if (res_if.res_idata[ACCW*l +: ACCW] !== ei || res_if.res_qdata[ACCW*l +: ACCW] !== eq) begin
        n_fail++;
        $display("FAIL sync_clean_frame lane %0d: got I=%0d required I=%0d", l,
                 $signed(res_if.res_idata[ACCW*l +: ACCW]), $signed(ei));
      end
    end
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
  endtask

  task automatic test_zero_length();
    logic [ACCW-1:0] ei, eq, edc;
    acc_length = '0;
    run        = 1'b1;
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_idle: got busy=%b serr=%b required 0/0", busy, sync_err);
    end
    acc_length = 16'd3;
    feed_frame(3, 2, 1);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_valid: got %b required 1", res_if.res_valid);
    end
    for (int l = 0; l < FREQ_NUM; l++) begin
      ei = ACCW'(exp_i[l]);
      eq = ACCW'(exp_q[l]);
      n_checks++;
      if (res_if.res_idata[ACCW*l +: ACCW] !== ei || res_if.res_qdata[ACCW*l +: ACCW] !== eq) begin
        n_fail++;
        $display("FAIL sparse_sum lane %0d: got I=%0d required I=%0d", l,
                 $signed(res_if.res_idata[ACCW*l +: ACCW]), $signed(ei));
      end
    end
`ifdef IQ_DEMOD_DC_SUM_EN
    edc = ACCW'(exp_dc);
`else
    edc = '0;
`endif
    n_checks++;
    if (res_if.res_dcdata !== edc) begin
      n_fail++;
      $display("FAIL sparse_dc: got %0d required %0d", $signed(res_if.res_dcdata), $signed(edc));
    end
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    longint          bi[NB2B][FREQ_NUM];
    longint          bq[NB2B][FREQ_NUM];
    logic [31:0]     r;
    logic signed [ADW-1:0] a;
    logic signed [15:0]    ip, qp;
    logic [ACCW-1:0] ei, eq;
    acc_length       = 16'd1;
    run              = 1'b1;
    res_if.res_ready = 1'b1;
    for (int i = 0; i < NB2B + 4; i++) begin
      if (i >= NB2B + 2) begin
        run         = 1'b0;
        sc_ad_valid = 1'b0;
      end else begin
        r = $urandom;
        a = r[ADW-1:0];
        ad_data     = a;
        sc_ad_valid = 1'b1;
        for (int l = 0; l < FREQ_NUM; l++) begin
          r  = $urandom;
          ip = r[15:0];
          qp = r[31:16];
          sc_ipcm_out[16*l +: 16] = ip;
          sc_qpcm_out[16*l +: 16] = qp;
          if (i >= 2) begin
            bi[i-2][l] = longint'(a) * longint'(ip);
            bq[i-2][l] = longint'(a) * longint'(qp);
          end
        end
      end
      step();
      if (i >= 4) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_valid frame %0d: got valid=%b ovr=%b required 1/0", i - 4,
                   res_if.res_valid, overrun);
        end
        for (int l = 0; l < FREQ_NUM; l++) begin
          ei = ACCW'(bi[i-4][l]);
          eq = ACCW'(bq[i-4][l]);
          n_checks++;
          if (res_if.res_idata[ACCW*l +: ACCW] !== ei ||
              res_if.res_qdata[ACCW*l +: ACCW] !== eq) begin
            n_fail++;
            $display("FAIL b2b_data frame %0d lane %0d: got I=%0d required I=%0d", i - 4, l,
                     $signed(res_if.res_idata[ACCW*l +: ACCW]), $signed(ei));
          end
        end
      end
    end
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid=%b required 0", res_if.res_valid);
    end
    res_if.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic            seen = 1'b0;
    logic [ACCW-1:0] ei, eq;
    acc_length = 16'd4;
    run        = 1'b1;
    feed_frame(2, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b valid=%b required 0/0", busy, res_if.res_valid);
    end
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      if (res_if.res_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_partial: a result appeared after reset, required none");
    end
    run = 1'b1;
    feed_frame(4, 2, 0);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rerun_valid: got %b required 1", res_if.res_valid);
    end
    for (int l = 0; l < FREQ_NUM; l++) begin
      ei = ACCW'(exp_i[l]);
      eq = ACCW'(exp_q[l]);
      n_checks++;
      if (res_if.res_idata[ACCW*l +: ACCW] !== ei || res_if.res_qdata[ACCW*l +: ACCW] !== eq) begin
        n_fail++;
        $display("FAIL reset_rerun lane %0d: got I=%0d required I=%0d", l,
                 $signed(res_if.res_idata[ACCW*l +: ACCW]), $signed(ei));
      end
    end
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
  endtask

  task automatic test_full_scale();
    logic [ACCW-1:0] eq, edc;
    acc_length = 16'd65535;
    run        = 1'b1;
    feed_frame(65535, 2, 2);
    run = 1'b0;
    sc_ad_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (res_if.res_valid !== 1'b1 ||
        $signed(res_if.res_idata[ACCW-1:0]) !== 48'sd17591917608960) begin
      n_fail++;
      $display("FAIL full_scale_i: got valid=%b I=%0d required 1 and 17591917608960",
               res_if.res_valid, $signed(res_if.res_idata[ACCW-1:0]));
    end
    eq = ACCW'(exp_q[0]);
    n_checks++;
    if (res_if.res_qdata[ACCW-1:0] !== eq) begin
      n_fail++;
      $display("FAIL full_scale_q: got %0d required %0d",
               $signed(res_if.res_qdata[ACCW-1:0]), $signed(eq));
    end
`ifdef IQ_DEMOD_DC_SUM_EN
    edc = ACCW'(exp_dc);
`else
    edc = '0;
`endif
    n_checks++;
    if (res_if.res_dcdata !== edc) begin
      n_fail++;
      $display("FAIL full_scale_dc: got %0d required %0d",
               $signed(res_if.res_dcdata), $signed(edc));
    end
    res_if.res_ready = 1'b1;
    step();
    res_if.res_ready = 1'b0;
  endtask

  initial begin
    res_if.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_sync_loss();
    test_zero_length();
    test_back_to_back();
    test_reset_mid_frame();
    test_full_scale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
